// File: rtl/pipe_memory.sv
// pipe_memory: single-port data/program memory with a valid/ready request
// channel, a READ_LAT-deep read pipeline and a clear sequencer that writes
// INIT_VAL to every word after each reset.
// Optional build macro: MEM_PARITY_EN adds an even-parity bit per word, an
// err_inject input (inverts stored parity on a write) and an rsp_err output.
module pipe_memory #(
  parameter int unsigned       DATA_W   = 8,
  parameter int unsigned       ADDR_W   = 8,
  parameter int unsigned       READ_LAT = 1,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_rw,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
`ifdef MEM_PARITY_EN
  input  logic              err_inject,
  output logic              rsp_err,
`endif
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              init_busy
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
`ifdef MEM_PARITY_EN
  localparam int unsigned MEM_W = DATA_W + 1;
`else
  localparam int unsigned MEM_W = DATA_W;
`endif

  // Reject unsupported pipeline depths at elaboration time
  if (READ_LAT < 1 || READ_LAT > 4) begin : g_bad_read_lat
    $error("pipe_memory: READ_LAT must be in 1..4");
  end

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W:0]     r_cnt;
  logic [ADDR_W:0]     w_cnt_nxt;
  logic                w_last;

  logic                r_req_ready;
  logic                r_init_busy;

  logic                w_acc;
  logic                w_wr_acc;
  logic                w_rd_acc;
  logic                w_we;
  logic [ADDR_W-1:0]   w_waddr;
  logic [DATA_W-1:0]   w_wdata;
  logic [MEM_W-1:0]    w_wword;

  logic [MEM_W-1:0]    r_mem [DEPTH];
  logic [MEM_W-1:0]    r_dpipe [READ_LAT];
  logic [MEM_W-1:0]    w_out_word;
  logic [READ_LAT-1:0] r_vld;

  logic                r_rsp_valid;
  logic [DATA_W-1:0]   r_rsp_rdata;
`ifdef MEM_PARITY_EN
  logic                r_rsp_err;
  logic                w_par_flip;
`endif

  // Clear sequencer is on its final word (counter is one bit wider, never wraps)
  assign w_last = (r_cnt == (ADDR_W+1)'(DEPTH - 1));

  // FSM state and clear counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_INIT;
      r_cnt       <= '0;
      r_req_ready <= 1'b0;
      r_init_busy <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_req_ready <= (w_state_nxt == ST_RUN);
      r_init_busy <= (w_state_nxt == ST_INIT);
    end
  end

  // FSM next state: INIT sweeps every address once, then RUN until reset
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_INIT: begin
        w_cnt_nxt = r_cnt + (ADDR_W+1)'(1);
        if (w_last) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        w_state_nxt = ST_RUN;
      end
      default: begin
        w_state_nxt = ST_INIT;
      end
    endcase
  end

  // Request decode and single write-port mux shared by INIT and CPU writes
  always_comb begin
    w_acc    = req_valid & r_req_ready;
    w_wr_acc = w_acc & req_rw;
    w_rd_acc = w_acc & ~req_rw;
    w_we     = 1'b0;
    w_waddr  = req_addr;
    w_wdata  = req_wdata;
`ifdef MEM_PARITY_EN
    w_par_flip = 1'b0;
`endif
    if (r_state == ST_INIT) begin
      w_we    = 1'b1;
      w_waddr = r_cnt[ADDR_W-1:0];
      w_wdata = INIT_VAL;
    end else begin
      w_we    = w_wr_acc;
`ifdef MEM_PARITY_EN
      w_par_flip = err_inject;
`endif
    end
`ifdef MEM_PARITY_EN
    w_wword = {(^w_wdata) ^ w_par_flip, w_wdata};
`else
    w_wword = w_wdata;
`endif
  end

  // Storage write port
  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[w_waddr] <= w_wword;
    end
  end

  // Synchronous read port plus data delay stages; qualified by r_vld
  always_ff @(posedge clk) begin
    if (w_rd_acc) begin
      r_dpipe[0] <= r_mem[req_addr];
    end
    for (int k = 1; k < int'(READ_LAT); k++) begin
      r_dpipe[k] <= r_dpipe[k-1];
    end
  end

  assign w_out_word = r_dpipe[READ_LAT-1];

  // Valid pipeline and registered response; reset drops in-flight reads
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
`ifdef MEM_PARITY_EN
      r_rsp_err   <= 1'b0;
`endif
    end else begin
      r_vld[0] <= w_rd_acc;
      for (int k = 1; k < int'(READ_LAT); k++) begin
        r_vld[k] <= r_vld[k-1];
      end
      r_rsp_valid <= r_vld[READ_LAT-1];
      if (r_vld[READ_LAT-1]) begin
        r_rsp_rdata <= w_out_word[DATA_W-1:0];
      end
`ifdef MEM_PARITY_EN
      r_rsp_err <= r_vld[READ_LAT-1] &
                   ((^w_out_word[DATA_W-1:0]) != w_out_word[DATA_W]);
`endif
    end
  end

  assign req_ready = r_req_ready;
  assign init_busy = r_init_busy;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
`ifdef MEM_PARITY_EN
  assign rsp_err   = r_rsp_err;
`endif

endmodule

// File: tb/tb_pipe_memory.sv
// Directed testbench for pipe_memory (DATA_W=8, ADDR_W=4, READ_LAT=2,
// INIT_VAL=8'hA5) with a scoreboard queue of expected read responses.
module tb_pipe_memory;

  localparam int unsigned DATA_W   = 8;
  localparam int unsigned ADDR_W   = 4;
  localparam int unsigned READ_LAT = 2;
  localparam logic [7:0]  INIT_V   = 8'hA5;

  typedef struct {
    logic [7:0] data;
    logic       err;
    int         due;
  } exp_t;

  logic              clk;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic              req_rw;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              init_busy;
  logic              err_inject;
  logic              rsp_err_obs;

  exp_t q[$];
  int   cyc;
  int   checks;
  int   errors;

  pipe_memory #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .READ_LAT(READ_LAT),
    .INIT_VAL(INIT_V)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_rw    (req_rw),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
`ifdef MEM_PARITY_EN
    .err_inject(err_inject),
    .rsp_err   (rsp_err_obs),
`endif
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .init_busy (init_busy)
  );

`ifndef MEM_PARITY_EN
  assign rsp_err_obs = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Response monitor: pop and compare on every rsp_valid, flag missing ones
  always @(negedge clk) begin
    if (!rst) begin
      if (rsp_valid) begin
        check("rsp_expected", 32'(q.size() != 0), 32'd1);
        if (q.size() != 0) begin
          exp_t e;
          e = q.pop_front();
          check("rsp_cycle", 32'(cyc), 32'(e.due));
          check("rsp_rdata", 32'(rsp_rdata), 32'(e.data));
`ifdef MEM_PARITY_EN
          check("rsp_err", 32'(rsp_err_obs), 32'(e.err));
`endif
        end
      end else if (q.size() != 0 && q[0].due < cyc) begin
        exp_t e;
        e = q.pop_front();
        checks++;
        errors++;
        $error("FAIL rsp_missing: observed no response at cycle %0d expected data %0h", e.due, e.data);
      end
    end
  end

  // One request in the cycle after the current posedge; reads are scoreboarded
  task automatic issue(input logic rw, input logic [3:0] addr, input logic [7:0] data,
                       input logic inj, input logic [7:0] exp_data, input logic exp_err);
    exp_t e;
    req_valid  = 1'b1;
    req_rw     = rw;
    req_addr   = addr;
    req_wdata  = data;
    err_inject = inj;
    if (!rw) begin
      e.data = exp_data;
      e.err  = exp_err;
      e.due  = cyc + 1 + int'(READ_LAT);
      q.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle();
    req_valid  = 1'b0;
    req_rw     = 1'b0;
    err_inject = 1'b0;
  endtask

  // Wait for scoreboard to empty, bounded
  task automatic drain(input string tag);
    int n;
    n = 0;
    while (q.size() != 0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check(tag, 32'(q.size()), 32'd0);
  endtask

  // Hold reset, release just after a posedge and track the INIT window
  task automatic reset_and_init(input string tag);
    rst = 1'b1;
    #1;
    check({tag, "_rst_ready"}, 32'(req_ready), 32'd0);
    check({tag, "_rst_busy"},  32'(init_busy), 32'd1);
    check({tag, "_rst_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_rst_rdata"}, 32'(rsp_rdata), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk); #1;
      check({tag, "_busy"},  32'(init_busy), 32'(i < 16));
      check({tag, "_ready"}, 32'(req_ready), 32'(i >= 16));
      check({tag, "_valid"}, 32'(rsp_valid), 32'd0);
    end
  endtask

  initial begin
    cyc        = 0;
    checks     = 0;
    errors     = 0;
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_rw     = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    err_inject = 1'b0;

    // Reset + INIT window, with a write to addr 0 held during INIT (ignored)
    @(posedge clk);
    req_valid = 1'b1;
    req_rw    = 1'b1;
    req_addr  = 4'd0;
    req_wdata = 8'hFF;
    reset_and_init("init1");
    idle();

    // Every word reads back INIT_VAL, back-to-back
    for (int a = 0; a < 16; a++) begin
      issue(1'b0, 4'(a), 8'h00, 1'b0, INIT_V, 1'b0);
    end
    idle();
    drain("drain_init_reads");

    // Write then immediate read of the same address
    issue(1'b1, 4'd4, 8'h3C, 1'b0, 8'h00, 1'b0);
    issue(1'b0, 4'd4, 8'h00, 1'b0, 8'h3C, 1'b0);
    idle();
    drain("drain_wr_rd");
    repeat (3) @(posedge clk);
    #1;
    check("rdata_hold", 32'(rsp_rdata), 32'h3C);
    check("valid_idle", 32'(rsp_valid), 32'd0);

    // Three writes then three back-to-back reads, in order
    issue(1'b1, 4'd1, 8'h11, 1'b0, 8'h00, 1'b0);
    issue(1'b1, 4'd2, 8'h22, 1'b0, 8'h00, 1'b0);
    issue(1'b1, 4'd3, 8'h33, 1'b0, 8'h00, 1'b0);
    issue(1'b0, 4'd1, 8'h00, 1'b0, 8'h11, 1'b0);
    issue(1'b0, 4'd2, 8'h00, 1'b0, 8'h22, 1'b0);
    issue(1'b0, 4'd3, 8'h00, 1'b0, 8'h33, 1'b0);
    idle();
    drain("drain_b2b");

    // Mixed stream: writes between reads must not disturb in-flight data
    issue(1'b0, 4'd1,  8'h00, 1'b0, 8'h11, 1'b0);
    issue(1'b1, 4'd1,  8'h44, 1'b0, 8'h00, 1'b0);
    issue(1'b0, 4'd1,  8'h00, 1'b0, 8'h44, 1'b0);
    issue(1'b1, 4'd15, 8'h5A, 1'b0, 8'h00, 1'b0);
    issue(1'b0, 4'd2,  8'h00, 1'b0, 8'h22, 1'b0);
    issue(1'b0, 4'd15, 8'h00, 1'b0, 8'h5A, 1'b0);
    idle();
    drain("drain_mixed");

`ifdef MEM_PARITY_EN
    // Parity: injected error is reported, a clean rewrite clears it
    issue(1'b1, 4'd9, 8'h07, 1'b1, 8'h00, 1'b0);
    issue(1'b0, 4'd9, 8'h00, 1'b0, 8'h07, 1'b1);
    issue(1'b1, 4'd9, 8'h07, 1'b0, 8'h00, 1'b0);
    issue(1'b0, 4'd9, 8'h00, 1'b0, 8'h07, 1'b0);
    idle();
    drain("drain_parity");
`endif

    // Reset one cycle after a read accept: response is dropped, INIT reruns
    issue(1'b1, 4'd6, 8'h66, 1'b0, 8'h00, 1'b0);
    req_valid = 1'b1;
    req_rw    = 1'b0;
    req_addr  = 4'd6;
    @(posedge clk); #1;
    idle();
    @(posedge clk); #1;
    reset_and_init("init2");
    idle();
    issue(1'b0, 4'd6, 8'h00, 1'b0, INIT_V, 1'b0);
    issue(1'b0, 4'd4, 8'h00, 1'b0, INIT_V, 1'b0);
    idle();
    drain("drain_after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_memory.md
Name: pipe_memory

Overview:
Parametrised single-port data/program memory for the 8-bit microprocessor and its wider variants.
- Adds a valid/ready request channel, a read pipeline of configurable latency, and a hardware clear sequencer that runs after every reset.
- Sits between the CPU load/store/fetch path and storage.
- The CPU waits on req_ready and consumes rsp_valid/rsp_rdata.

Parameters:
- DATA_W, 8: word width in bits.
- ADDR_W, 8: address width in bits. DEPTH = 2**ADDR_W words.
- READ_LAT, 1: read latency in cycles. Legal range 1..4.
- INIT_VAL, 0: DATA_W-bit value written to every word by the clear sequencer.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block accepts a request this cycle.
- req_rw  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_W  write data.
- rsp_valid  out  1  read data valid; single-cycle pulse per read.
- rsp_rdata  out  DATA_W  read data.
- init_busy  out  1  clear sequencer active.

Behaviour:
- Reset (async, active-high) forces, immediately and for as long as rst is high:
  - req_ready=0, rsp_valid=0, rsp_rdata=0, init_busy=1.
  - Read pipeline flushed; clear counter=0; FSM=INIT.
  - Memory contents are not touched by reset itself.
- FSM states: INIT, RUN.
  - INIT: one word per cycle, mem[cnt] <= INIT_VAL, cnt increments. Takes exactly DEPTH cycles after rst falls.
  - INIT -> RUN on the edge that writes address DEPTH-1. No counter wrap; cnt is ADDR_W+1 bits or uses an explicit last flag.
  - RUN: init_busy=0, req_ready=1 every cycle. RUN has no exit except rst.
- Transfer: occurs on a rising edge where req_valid && req_ready. Requests with req_ready=0 are ignored, not queued.
- Write transfer: mem[req_addr] <= req_wdata at that edge. No response is generated.
- Read transfer:
  - Data is sampled at the accept edge: contents before any write in the same cycle. Only one request per cycle is possible.
  - rsp_valid=1 with rsp_rdata=data exactly READ_LAT cycles after the accept edge.
  - Fully pipelined: one read per cycle is sustained, and responses return in order.
- Read of an address written in the previous transfer returns the new data.
- rsp_rdata holds its last value when rsp_valid=0.
- The response channel has no backpressure; the consumer must always accept.
- Mixed write/read streams: write transfers do not disturb in-flight read responses.
- Reset mid-operation:
  - In-flight reads are dropped; rsp_valid falls asynchronously.
  - After rst falls, INIT restarts from address 0 and re-clears the whole array.
- Address is full-range; no out-of-range case exists.
- Memory is inferable as block RAM: one write port, one synchronous read port. The INIT write shares the single write port.

Optional Feature:
Macro MEM_PARITY_EN.
- Defined:
  - Each word stores DATA_W+1 bits: data plus even parity.
  - Extra input err_inject (1 bit): when high on a write transfer, the stored parity bit is inverted.
  - INIT writes correct parity.
  - Extra output rsp_err (1 bit, reset 0) is valid with rsp_valid. It is 1 when the recomputed parity differs from the stored parity, and 0 when rsp_valid=0.
- Undefined: err_inject and rsp_err ports do not exist, and storage is DATA_W bits.

Test Plan:
All scenarios use DATA_W=8, ADDR_W=4, READ_LAT=2, INIT_VAL=8'hA5 unless stated.
1. Reset, release rst -> init_busy=1 and req_ready=0 for exactly 16 cycles, then init_busy=0 and req_ready=1; reads of addresses 0..15 all return 8'hA5.
2. Write 8'h3C to addr 4, then read addr 4 on the next cycle -> rsp_valid pulses 2 cycles after the read accept edge with rsp_rdata=8'h3C.
3. Back-to-back reads of addrs 1,2,3 on consecutive cycles after writing 8'h11, 8'h22, 8'h33 -> rsp_valid high for 3 consecutive cycles with data 11, 22, 33 in order.
4. Requests issued during INIT: req_valid=1, write 8'hFF to addr 0 -> ignored; after INIT, a read of addr 0 returns 8'hA5.
5. Assert rst one cycle after a read accept -> rsp_valid stays 0 and no response appears; INIT reruns for 16 cycles.
6. With MEM_PARITY_EN: write 8'h07 to addr 9 with err_inject=1, then read it -> rsp_rdata=8'h07, rsp_err=1. A normal write and read of the same address -> rsp_err=0.
